// File: rtl/cpu_control_stepper.sv
// cpu_control_stepper: six-step fetch/execute sequencer for the 8-bit CPU.
// A step counter walks 1..6. Every datapath enable/set line is decoded
// combinationally from the current step, the IR contents and the flags.
// Steps 1-3 fetch the instruction; steps 4-6 execute it.
module cpu_control_stepper (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       run_i,
   input  logic [7:0] ir_in_i,
   input  logic [3:0] flags_in_i,
   output logic [2:0] step_o,
   output logic       e_b1_o,
   output logic       e_iar_o,
   output logic       s_iar_o,
   output logic       s_mar_o,
   output logic       e_ram_o,
   output logic       s_ram_o,
   output logic       s_ir_o,
   output logic       e_acc_o,
   output logic       s_acc_o,
   output logic       s_tmp_o,
   output logic       s_flags_o,
   output logic       clr_flags_o,
   output logic [2:0] alu_op_o,
   output logic [3:0] e_reg_o,
   output logic [3:0] s_reg_o
);

   logic [2:0] step_q, step_d;
   logic [3:0] ra_oh, rb_oh;
   logic [2:0] opc;
   logic       active;

   assign step_o = step_q;
   assign ra_oh  = 4'b0001 << ir_in_i[5:4];
   assign rb_oh  = 4'b0001 << ir_in_i[3:2];
   assign opc    = ir_in_i[6:4];
   // Reset wins over run; either one blanks every control line.
   assign active = run_i & ~reset_i;

   // Next step: 6 wraps to 1; an out-of-range value also recovers to 1.
   always_comb begin
      if (step_q >= 3'd6 || step_q == 3'd0) step_d = 3'd1;
      else                                  step_d = step_q + 3'd1;
   end

   // Step counter: reset to 1, advance only while running.
   always_ff @(posedge clk_i) begin
      if (reset_i)    step_q <= 3'd1;
      else if (run_i) step_q <= step_d;
   end

   // Control decode: fetch steps are fixed, execute steps depend on the IR.
   always_comb begin
      e_b1_o      = 1'b0;
      e_iar_o     = 1'b0;
      s_iar_o     = 1'b0;
      s_mar_o     = 1'b0;
      e_ram_o     = 1'b0;
      s_ram_o     = 1'b0;
      s_ir_o      = 1'b0;
      e_acc_o     = 1'b0;
      s_acc_o     = 1'b0;
      s_tmp_o     = 1'b0;
      s_flags_o   = 1'b0;
      clr_flags_o = 1'b0;
      alu_op_o    = 3'b000;
      e_reg_o     = 4'b0000;
      s_reg_o     = 4'b0000;
      if (active) begin
         case (step_q)
            // ACC <= IAR + 1, MAR <= IAR
            3'd1: begin
               e_b1_o  = 1'b1;
               e_iar_o = 1'b1;
               s_mar_o = 1'b1;
               s_acc_o = 1'b1;
            end
            3'd2: begin
               e_ram_o = 1'b1;
               s_ir_o  = 1'b1;
            end
            3'd3: begin
               e_acc_o = 1'b1;
               s_iar_o = 1'b1;
            end
            3'd4, 3'd5, 3'd6: begin
               if (ir_in_i[7]) begin
                  // ALU: TMP <= RB; ACC <= RA op TMP; RB <= ACC (not for CMP)
                  case (step_q)
                     3'd4: begin
                        e_reg_o = rb_oh;
                        s_tmp_o = 1'b1;
                     end
                     3'd5: begin
                        e_reg_o   = ra_oh;
                        s_acc_o   = 1'b1;
                        s_flags_o = 1'b1;
                        alu_op_o  = opc;
                     end
                     default: begin
                        if (opc != 3'b111) begin
                           e_acc_o = 1'b1;
                           s_reg_o = rb_oh;
                        end
                     end
                  endcase
               end else begin
                  case (opc)
                     // LOAD / STORE: MAR <= RA, then RAM <-> RB
                     3'd0, 3'd1: begin
                        if (step_q == 3'd4) begin
                           e_reg_o = ra_oh;
                           s_mar_o = 1'b1;
                        end else if (step_q == 3'd5) begin
                           if (opc == 3'd0) begin
                              e_ram_o = 1'b1;
                              s_reg_o = rb_oh;
                           end else begin
                              e_reg_o = rb_oh;
                              s_ram_o = 1'b1;
                           end
                        end
                     end
                     // DATA: fetch the immediate byte into RB and skip over it
                     3'd2: begin
                        if (step_q == 3'd4) begin
                           e_b1_o  = 1'b1;
                           e_iar_o = 1'b1;
                           s_mar_o = 1'b1;
                           s_acc_o = 1'b1;
                        end else if (step_q == 3'd5) begin
                           e_ram_o = 1'b1;
                           s_reg_o = rb_oh;
                        end else begin
                           e_acc_o = 1'b1;
                           s_iar_o = 1'b1;
                        end
                     end
                     // JMPR: IAR <= RB
                     3'd3: begin
                        if (step_q == 3'd4) begin
                           e_reg_o = rb_oh;
                           s_iar_o = 1'b1;
                        end
                     end
                     // JMP: IAR <= mem[IAR]
                     3'd4: begin
                        if (step_q == 3'd4) begin
                           e_iar_o = 1'b1;
                           s_mar_o = 1'b1;
                        end else if (step_q == 3'd5) begin
                           e_ram_o = 1'b1;
                           s_iar_o = 1'b1;
                        end
                     end
                     // JCAEZ: step past the target, then jump only if a masked flag is set
                     3'd5: begin
                        if (step_q == 3'd4) begin
                           e_b1_o  = 1'b1;
                           e_iar_o = 1'b1;
                           s_mar_o = 1'b1;
                           s_acc_o = 1'b1;
                        end else if (step_q == 3'd5) begin
                           e_acc_o = 1'b1;
                           s_iar_o = 1'b1;
                        end else if ((ir_in_i[3:0] & flags_in_i) != 4'b0000) begin
                           e_ram_o = 1'b1;
                           s_iar_o = 1'b1;
                        end
                     end
                     // CLF
                     3'd6: begin
                        if (step_q == 3'd4) clr_flags_o = 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_control_stepper.sv
// tb_cpu_control_stepper: directed bench with a step/micro-op model that is
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_cpu_control_stepper;

   logic       clk = 1'b0;
   logic       reset, run;
   logic [7:0] ir;
   logic [3:0] flags;
   logic [2:0] step, alu_op;
   logic       e_b1, e_iar, s_iar, s_mar, e_ram, s_ram, s_ir;
   logic       e_acc, s_acc, s_tmp, s_flags, clr_flags;
   logic [3:0] e_reg, s_reg;

   int checks = 0;
   int failures = 0;

   logic [2:0] mstep = 3'd0;
   logic       mknown = 1'b0;

   always #5 clk = ~clk;

   cpu_control_stepper dut (
      .clk_i(clk), .reset_i(reset), .run_i(run), .ir_in_i(ir), .flags_in_i(flags),
      .step_o(step), .e_b1_o(e_b1), .e_iar_o(e_iar), .s_iar_o(s_iar), .s_mar_o(s_mar),
      .e_ram_o(e_ram), .s_ram_o(s_ram), .s_ir_o(s_ir), .e_acc_o(e_acc), .s_acc_o(s_acc),
      .s_tmp_o(s_tmp), .s_flags_o(s_flags), .clr_flags_o(clr_flags), .alu_op_o(alu_op),
      .e_reg_o(e_reg), .s_reg_o(s_reg)
   );

   // {step, e_b1,e_iar,s_iar,s_mar,e_ram,s_ram,s_ir,e_acc,s_acc,s_tmp,s_flags,clr_flags, alu_op, e_reg, s_reg}
   logic [25:0] dut_vec;
   assign dut_vec = {step, e_b1, e_iar, s_iar, s_mar, e_ram, s_ram, s_ir, e_acc, s_acc,
                     s_tmp, s_flags, clr_flags, alu_op, e_reg, s_reg};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Instruction-level model: which micro-ops happen in which step of which instruction.
   function automatic logic [25:0] model(input logic [2:0] st, input logic [7:0] i,
                                         input logic [3:0] fl, input logic act);
      logic [3:0] op, ra, rb, er, sr;
      logic [2:0] alu;
      logic b1, eiar, siar, smar, eram, sram, sir, eacc, sacc, stmp, sfl, cfl;
      op = i[7:4];
      ra = 4'b0001 << i[5:4];
      rb = 4'b0001 << i[3:2];
      {b1, eiar, siar, smar, eram, sram, sir, eacc, sacc, stmp, sfl, cfl} = '0;
      alu = 3'b000; er = 4'b0000; sr = 4'b0000;
      if (act) begin
         if (st == 1 || (st == 4 && (op == 2 || op == 5))) begin
            b1 = 1; eiar = 1; smar = 1; sacc = 1;          // ACC <= IAR+1, MAR <= IAR
         end else if (st == 3 || (st == 6 && op == 2) || (st == 5 && op == 5)) begin
            eacc = 1; siar = 1;                             // IAR <= ACC
         end else if (st == 2) begin
            eram = 1; sir = 1;
         end else if (op[3]) begin
            if (st == 4) begin er = rb; stmp = 1; end
            else if (st == 5) begin er = ra; sacc = 1; sfl = 1; alu = i[6:4]; end
            else if (st == 6 && i[6:4] != 3'b111) begin eacc = 1; sr = rb; end
         end
         else if ((op == 0 || op == 1) && st == 4) begin er = ra; smar = 1; end
         else if ((op == 0 || op == 2) && st == 5) begin eram = 1; sr = rb; end
         else if (op == 1 && st == 5) begin er = rb; sram = 1; end
         else if (op == 3 && st == 4) begin er = rb; siar = 1; end
         else if (op == 4 && st == 4) begin eiar = 1; smar = 1; end
         else if (op == 4 && st == 5) begin eram = 1; siar = 1; end
         else if (op == 5 && st == 6 && (i[3:0] & fl) != 4'b0000) begin eram = 1; siar = 1; end
         else if (op == 6 && st == 4) cfl = 1;
      end
      return {st, b1, eiar, siar, smar, eram, sram, sir, eacc, sacc, stmp, sfl, cfl, alu, er, sr};
   endfunction

   // Reference step counter.
   always @(posedge clk) begin
      if (reset) begin
         mstep  <= 3'd1;
         mknown <= 1'b1;
      end else if (run && mknown) begin
         mstep <= (mstep == 3'd6) ? 3'd1 : mstep + 3'd1;
      end
   end

   // Every-cycle comparison against the model plus structural invariants.
   always @(negedge clk) begin
      if (mknown) begin
         chk("model", {6'b0, dut_vec}, {6'b0, model(mstep, ir, flags, run && !reset)});
         chk("bus_excl", 32'(int'(e_iar) + int'(e_ram) + int'(e_acc) + $countones(e_reg) <= 1), 32'd1);
         chk("ereg_onehot", {31'b0, $onehot0(e_reg)}, 32'd1);
         chk("sreg_onehot", {31'b0, $onehot0(s_reg)}, 32'd1);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [22:0] ctl();
      return dut_vec[22:0];
   endfunction

   initial begin
      reset = 1'b1; run = 1'b0; ir = 8'h00; flags = 4'h0;
      tick; tick;
      chk("reset_ctl", {9'b0, ctl()}, 32'd0);
      reset = 1'b0; run = 1'b1;
      #1;
      // Fetch: 1,2,3,4,5,6,1
      chk("step1", step, 1);
      chk("fetch1", {e_b1, e_iar, s_mar, s_acc}, 4'b1111);
      tick; chk("step2", step, 2); chk("fetch2", {e_ram, s_ir}, 2'b11);
      tick; chk("step3", step, 3); chk("fetch3", {e_acc, s_iar}, 2'b11);
      tick; chk("step4", step, 4);
      tick; chk("step5", step, 5);
      tick; chk("step6", step, 6);
      tick; chk("wrap1", step, 1);

      // ADD R0,R1
      ir = 8'h86;
      tick; tick; tick;
      chk("add4_ereg", e_reg, 4'b0010); chk("add4_tmp", s_tmp, 1);
      tick;
      chk("add5_ereg", e_reg, 4'b0001); chk("add5_set", {s_acc, s_flags}, 2'b11);
      chk("add5_alu", alu_op, 3'b000);
      tick;
      chk("add6_eacc", e_acc, 1); chk("add6_sreg", s_reg, 4'b0010);
      tick;

      // CMP: no write-back
      ir = 8'hF6;
      tick; tick; tick; tick;
      chk("cmp5_alu", alu_op, 3'b111);
      tick;
      chk("cmp6_none", {9'b0, ctl()}, 32'd0);
      tick;

      // LOAD 0x0B: RA=R0, RB=R2
      ir = 8'h0B;
      tick; tick; tick;
      chk("load4", {e_reg, s_mar}, 5'b0001_1);
      tick;
      chk("load5", {e_ram, s_reg}, 5'b1_0100);
      tick; tick;

      // STORE 0x1B: RA=R1, RB=R2
      ir = 8'h1B;
      tick; tick; tick;
      chk("store4", {e_reg, s_mar}, 5'b0010_1);
      tick;
      chk("store5", {e_reg, s_ram}, 5'b0100_1);
      tick; tick;

      // JCAEZ with C mask: taken, then not taken
      ir = 8'h58; flags = 4'b1000;
      tick; tick; tick; tick; tick;
      chk("jc_taken", {e_ram, s_iar}, 2'b11);
      tick;
      flags = 4'b0111;
      tick; tick; tick; tick; tick;
      chk("jc_not", {9'b0, ctl()}, 32'd0);
      tick;

      // Hold at step 4 for 3 clocks
      ir = 8'h86;
      tick; tick; tick;
      run = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("hold_ctl", {9'b0, ctl()}, 32'd0);
         tick;
         chk("hold_step", step, 4);
      end
      run = 1'b1;
      #1;
      chk("resume4", {e_reg, s_tmp}, 5'b0010_1);
      tick; chk("resume5", step, 5);
      tick; chk("resume6", s_reg, 4'b0010);
      tick;

      // Reset at step 5
      tick; tick; tick; tick;
      reset = 1'b1;
      #1;
      chk("rst5_step", step, 5);
      chk("rst5_ctl", {9'b0, ctl()}, 32'd0);
      tick;
      reset = 1'b0;
      #1;
      chk("rst_step1", step, 1);
      chk("rst_fetch", {e_b1, e_iar, s_mar, s_acc}, 4'b1111);

      // Sweep every opcode through all six steps
      for (int i = 0; i < 256; i++) begin
         ir = 8'(i);
         flags = ir[7:4] ^ ir[3:0];
         repeat (6) tick;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
